// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          WORD_W    = 32;
    localparam int          PC_W      = 32;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
// Handshake: an entry moves only when its valid is high and the receiver's stall is low
// on the same rising edge; flushD overrides both directions and empties the queue.
interface fetch_decode_queue_if #(
    parameter int counter_width = 32,
    parameter int word_width    = 32,
    parameter int depth         = 4
);
    logic                         validF;
    logic [word_width-1:0]        InstrF;
    logic [counter_width-1:0]     PCF;
    logic [counter_width-1:0]     PCPlus4F;
    logic                         stallF;
    logic                         validD;
    logic [word_width-1:0]        InstrD;
    logic [counter_width-1:0]     PCD;
    logic [counter_width-1:0]     PCPlus4D;
    logic                         stallD;
    logic                         flushD;
    logic [$clog2(depth+1)-1:0]   countQ;

    modport master (
        output validF, InstrF, PCF, PCPlus4F, stallD, flushD,
        input  stallF, validD, InstrD, PCD, PCPlus4D, countQ
    );

    modport slave (
        input  validF, InstrF, PCF, PCPlus4F, stallD, flushD,
        output stallF, validD, InstrD, PCD, PCPlus4D, countQ
    );
endinterface

// File: rtl/fetch_decode_queue_mem.sv
// Queue storage: register array with one synchronous write and one asynchronous read port.
module fetch_queue_mem
    import pipeline_pkg::*;
#(
    parameter int  depth   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(depth)-1:0] i_waddr,
    input  entry_t                   i_wdata,
    input  logic [$clog2(depth)-1:0] i_raddr,
    output entry_t                   o_rdata
);

    // No reset: stale contents are hidden by the occupancy-derived valid.
    entry_t r_mem [depth];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction FIFO between fetch and decode: absorbs decode stalls, back-pressures fetch
// when full, and empties on a taken branch/jump from execute.
module fetch_decode_queue
    import pipeline_pkg::*;
#(
    parameter int counter_width = 32,
    parameter int word_width    = 32,
    parameter int depth         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_decode_queue_if.slave    bus
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth+1);

    typedef struct packed {
        logic [word_width-1:0]    instr;
        logic [counter_width-1:0] pc;
        logic [counter_width-1:0] pcplus4;
    } q_entry_t;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic     w_full;
    logic     w_valid;
    logic     w_enq;
    logic     w_deq;
    q_entry_t w_wr_entry;
    q_entry_t w_head;

    // Status comes only from the registered count, so fetch never sees a path from stallD.
    assign w_full  = (r_count == CNT_W'(depth));
    assign w_valid = (r_count != '0);

    assign w_enq = bus.validF && !w_full && !bus.flushD;
    assign w_deq = w_valid && !bus.stallD && !bus.flushD;

    assign w_wr_entry = '{instr: bus.InstrF, pc: bus.PCF, pcplus4: bus.PCPlus4F};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flushD) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);
        end
    end

    fetch_queue_mem #(
        .depth   (depth),
        .entry_t (q_entry_t)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign bus.stallF   = w_full;
    assign bus.validD   = w_valid;
    assign bus.countQ   = r_count;
    assign bus.InstrD   = w_valid ? w_head.instr   : word_width'(NOP_INSTR);
    assign bus.PCD      = w_valid ? w_head.pc      : '0;
    assign bus.PCPlus4D = w_valid ? w_head.pcplus4 : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t model_q[$];

  always #5 clk = ~clk;

  fetch_decode_queue_if #(.counter_width(32), .word_width(32), .depth(DEPTH)) bus();

  fetch_decode_queue #(.counter_width(32), .word_width(32), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic ent_t exp_head();
    ent_t e;
    if (model_q.size() != 0) e = model_q[0];
    else e = '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
    return e;
  endfunction

  // Drive one cycle of stimulus (from a negedge) and advance the reference model.
  task automatic tick(input bit vf, input logic [31:0] pc, input bit sd, input bit fl);
    ent_t e;
    bit enq, deq;
    e.instr = $urandom;
    e.pc = pc;
    e.pc4 = pc + 32'd4;
    bus.validF = vf;
    bus.InstrF = e.instr;
    bus.PCF = e.pc;
    bus.PCPlus4F = e.pc4;
    bus.stallD = sd;
    bus.flushD = fl;
    enq = vf && (model_q.size() < DEPTH) && !fl;
    deq = (model_q.size() != 0) && !sd && !fl;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(e);
    end
    @(negedge clk);
    bus.validF = 1'b0;
    bus.stallD = 1'b1;
    bus.flushD = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL reset_validD: got %b expected 0", bus.validD); end
    checks++; if (bus.InstrD !== NOP_INSTR) begin errors++; $display("FAIL reset_InstrD: got %h expected %h", bus.InstrD, NOP_INSTR); end
    checks++; if (bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h expected 0/0", bus.PCD, bus.PCPlus4D); end
    checks++; if (bus.stallF !== 1'b0) begin errors++; $display("FAIL reset_stallF: got %b expected 0", bus.stallF); end
    checks++; if (bus.countQ !== 3'd0) begin errors++; $display("FAIL reset_countQ: got %0d expected 0", bus.countQ); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0);
    checks++; if (bus.countQ !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", bus.countQ); end
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL mid_validD: got %b expected 0", bus.validD); end
    checks++; if (bus.InstrD !== NOP_INSTR) begin errors++; $display("FAIL mid_InstrD: got %h expected %h", bus.InstrD, NOP_INSTR); end
    checks++; if (bus.countQ !== 3'd0) begin errors++; $display("FAIL mid_countQ: got %0d expected 0", bus.countQ); end
    checks++; if (bus.stallF !== 1'b0) begin errors++; $display("FAIL mid_stallF: got %b expected 0", bus.stallF); end
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, 32'h0, 1'b1, 1'b0);
    checks++; if (bus.validD !== 1'b1 || bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h4) begin
      errors++; $display("FAIL mid_first_push: got v=%b pc=%h pc4=%h expected v=1 pc=0 pc4=4", bus.validD, bus.PCD, bus.PCPlus4D); end
    checks++; if (bus.InstrD !== model_q[0].instr) begin errors++; $display("FAIL mid_first_instr: got %h expected %h", bus.InstrD, model_q[0].instr); end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(i * 4), 1'b1, 1'b0);
    checks++; if (bus.countQ !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", bus.countQ); end
    checks++; if (bus.stallF !== 1'b1) begin errors++; $display("FAIL fill_stallF: got %b expected 1", bus.stallF); end
    tick(1'b1, 32'h10, 1'b1, 1'b0);
    checks++; if (bus.countQ !== 3'd4) begin errors++; $display("FAIL fill_refused_count: got %0d expected 4", bus.countQ); end
    checks++; if (bus.PCD !== 32'h0) begin errors++; $display("FAIL fill_head: got %h expected 0", bus.PCD); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.validD !== 1'b1 || bus.PCD !== 32'(i * 4) || bus.PCPlus4D !== 32'(i * 4 + 4)) begin
        errors++; $display("FAIL drain_%0d: got v=%b pc=%h pc4=%h expected v=1 pc=%h pc4=%h", i, bus.validD, bus.PCD, bus.PCPlus4D, i * 4, i * 4 + 4); end
      checks++; if (bus.InstrD !== model_q[0].instr) begin errors++; $display("FAIL drain_instr_%0d: got %h expected %h", i, bus.InstrD, model_q[0].instr); end
      // first drain cycle offers PC 0x10 while still full: it must be refused
      tick(i == 0, 32'h10, 1'b0, 1'b0);
    end
    checks++; if (bus.validD !== 1'b0 || bus.InstrD !== NOP_INSTR || bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0) begin
      errors++; $display("FAIL drain_empty: got v=%b i=%h pc=%h pc4=%h expected 0/00000013/0/0", bus.validD, bus.InstrD, bus.PCD, bus.PCPlus4D); end
    checks++; if (bus.countQ !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", bus.countQ); end
  endtask

  task automatic test_simultaneous;
    tick(1'b1, 32'h100, 1'b1, 1'b0);
    tick(1'b1, 32'h104, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.countQ !== 3'd2) begin errors++; $display("FAIL simul_count_%0d: got %0d expected 2", k, bus.countQ); end
      checks++; if (bus.PCD !== 32'h100 + 32'(k * 4)) begin errors++; $display("FAIL simul_order_%0d: got %h expected %h", k, bus.PCD, 32'h100 + 32'(k * 4)); end
      tick(1'b1, 32'h108 + 32'(k * 4), 1'b0, 1'b0);
    end
    checks++; if (bus.countQ !== 3'd2) begin errors++; $display("FAIL simul_count_end: got %0d expected 2", bus.countQ); end
  endtask

  task automatic test_flush;
    tick(1'b1, 32'h120, 1'b1, 1'b0);
    checks++; if (bus.countQ !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", bus.countQ); end
    tick(1'b1, 32'h40, 1'b0, 1'b1);
    checks++; if (bus.countQ !== 3'd0 || bus.validD !== 1'b0) begin errors++; $display("FAIL flush_empty: got count=%0d v=%b expected 0/0", bus.countQ, bus.validD); end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (bus.validD !== 1'b0 || bus.PCD === 32'h40) begin errors++; $display("FAIL flush_no_leak: got v=%b pc=%h expected v=0 and pc!=40", bus.validD, bus.PCD); end
  endtask

  task automatic test_wrap;
    int next_push = 0;
    int next_pop = 0;
    int cyc = 0;
    bit sd, vf;
    ent_t eh;
    while (next_pop < 10 && cyc < 200) begin
      sd = ($urandom_range(0, 2) == 0);
      vf = (next_push < 10) && ($urandom_range(0, 3) != 0);
      eh = exp_head();
      checks++; if (bus.PCD !== eh.pc || bus.PCPlus4D !== eh.pc4 || bus.InstrD !== eh.instr) begin
        errors++; $display("FAIL wrap_head: got %h/%h/%h expected %h/%h/%h", bus.InstrD, bus.PCD, bus.PCPlus4D, eh.instr, eh.pc, eh.pc4); end
      checks++; if (bus.countQ !== 3'(model_q.size()) || bus.validD !== (model_q.size() != 0) || bus.stallF !== (model_q.size() == DEPTH)) begin
        errors++; $display("FAIL wrap_status: got c=%0d v=%b sf=%b expected c=%0d", bus.countQ, bus.validD, bus.stallF, model_q.size()); end
      if (model_q.size() != 0 && !sd) begin
        checks++; if (bus.PCD !== 32'(next_pop * 4)) begin errors++; $display("FAIL wrap_order: got %h expected %h", bus.PCD, next_pop * 4); end
        next_pop++;
      end
      if (vf) begin
        tick(1'b1, 32'(next_push * 4), sd, 1'b0);
        if (model_q.size() != 0 && model_q[model_q.size()-1].pc == 32'(next_push * 4)) next_push++;
      end else tick(1'b0, 32'h0, sd, 1'b0);
      cyc++;
    end
    checks++; if (next_pop != 10) begin errors++; $display("FAIL wrap_timeout: got %0d pops expected 10", next_pop); end
  endtask

  task automatic test_random;
    bit vf, sd, fl;
    ent_t eh;
    for (int c = 0; c < 80; c++) begin
      vf = $urandom_range(0, 1);
      sd = $urandom_range(0, 1);
      fl = ($urandom_range(0, 15) == 0);
      eh = exp_head();
      checks++; if (bus.PCD !== eh.pc || bus.PCPlus4D !== eh.pc4 || bus.InstrD !== eh.instr) begin
        errors++; $display("FAIL rand_head_%0d: got %h/%h/%h expected %h/%h/%h", c, bus.InstrD, bus.PCD, bus.PCPlus4D, eh.instr, eh.pc, eh.pc4); end
      checks++; if (bus.countQ !== 3'(model_q.size()) || bus.validD !== (model_q.size() != 0) || bus.stallF !== (model_q.size() == DEPTH)) begin
        errors++; $display("FAIL rand_status_%0d: got c=%0d v=%b sf=%b expected c=%0d", c, bus.countQ, bus.validD, bus.stallF, model_q.size()); end
      tick(vf, {$urandom_range(0, 32'h3fff_ffff), 2'b00}, sd, fl);
    end
  endtask

  initial begin
    bus.validF = 1'b0;
    bus.InstrF = '0;
    bus.PCF = '0;
    bus.PCPlus4F = '0;
    bus.stallD = 1'b1;
    bus.flushD = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_reset_midstream;
    test_fill;
    test_drain;
    test_simultaneous;
    test_flush;
    test_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
